// File: rtl/scalar_fu_pkg.sv
// Shared definitions for the scalar function unit and its command sequencer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package scalar_fu_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int ALUOP_WIDTH = 3;

  typedef enum logic [ALUOP_WIDTH-1:0] {
    ADD = 3'd0,
    SNA = 3'd1,
    MUL = 3'd2,
    LSH = 3'd3,
    RSH = 3'd4
  } aluop_t;

  // Opcodes above RSH have no FU implementation and must be rejected.
  function automatic logic is_legal_aluop(input logic [ALUOP_WIDTH-1:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/scalar_fu_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth, occupancy counter of log2(DEPTH)+1 bits.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored while full (a same-cycle pop does not free a slot); pop ignored while empty.
module scalar_fu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scalar_fu_seq.sv
// Scalar FU command sequencer: queues ops, drives the FU operands, captures out and returns it with its tag.
// Latency: result held FU_LAT cycles on the FU; one op per FU_LAT+2 cycles; illegal opcodes skip the FU.
// Backpressure: cmd_ready = FIFO not full; a stalled response holds the FSM in RESP while the FIFO fills.
// Optional: SCALAR_FU_SEQ_SAT_EN saturates results to the signed DATA_WIDTH range and adds rsp_sat.
module scalar_fu_seq #(
  parameter int DATA_WIDTH  = scalar_fu_pkg::DATA_WIDTH,
  parameter int ALUOP_WIDTH = scalar_fu_pkg::ALUOP_WIDTH,
  parameter int TAG_WIDTH   = 4,
  parameter int DEPTH       = 4,
  parameter int FU_LAT      = 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ALUOP_WIDTH-1:0]  cmd_aluop,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  input  logic [TAG_WIDTH-1:0]    cmd_tag,
  output logic [DATA_WIDTH-1:0]   fu_a,
  output logic [DATA_WIDTH-1:0]   fu_b,
  output logic [ALUOP_WIDTH-1:0]  fu_aluop,
  input  logic [2*DATA_WIDTH-1:0] fu_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]    rsp_tag,
  output logic                    rsp_err,
  output logic                    busy
`ifdef SCALAR_FU_SEQ_SAT_EN
  ,
  output logic                    rsp_sat
`endif
);

  import scalar_fu_pkg::*;

  localparam int RW     = 2*DATA_WIDTH;
  localparam int CW     = $clog2(FU_LAT+1);
  localparam int PKG_AW = scalar_fu_pkg::ALUOP_WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [ALUOP_WIDTH-1:0] aluop;
    logic [DATA_WIDTH-1:0]  a;
    logic [DATA_WIDTH-1:0]  b;
    logic [TAG_WIDTH-1:0]   tag;
  } cmd_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [TAG_WIDTH-1:0] op_tag;
  cmd_t                 cmd_in, head;
  logic                 full, empty, pop;
  logic [$clog2(DEPTH):0] count;
  logic                 issue, reject, capture;
  logic [RW-1:0]        res_d;
  logic                 res_clip;

  assign cmd_in    = '{aluop: cmd_aluop, a: cmd_a, b: cmd_b, tag: cmd_tag};
  assign cmd_ready = !full;
  assign rsp_valid = (state == RESP);
  assign busy      = (count != '0) || (state != IDLE);

  scalar_fu_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .push      (cmd_valid && cmd_ready),
    .push_data (cmd_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

`ifdef SCALAR_FU_SEQ_SAT_EN
  // Clip to the signed DATA_WIDTH range when the upper bits are not a pure sign extension.
  always_comb begin
    res_clip = !((&fu_out[RW-1:DATA_WIDTH-1]) || !(|fu_out[RW-1:DATA_WIDTH-1]));
    res_d    = fu_out;
    if (res_clip) begin
      res_d = fu_out[RW-1] ? {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}}
                           : {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_d    = fu_out;
  assign res_clip = 1'b0;
`endif

  // Next-state and per-cycle strobes: pop/issue in IDLE, count down in EXEC, wait for handshake in RESP.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pop     = 1'b0;
    issue   = 1'b0;
    reject  = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (is_legal_aluop(PKG_AW'(head.aluop))) begin
            issue   = 1'b1;
            cnt_d   = CW'(FU_LAT-1);
            state_d = EXEC;
          end else begin
            reject  = 1'b1;
            state_d = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and FU hold counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // FU operand registers change only when a legal op is issued, so the FU sees no idle toggling.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fu_a     <= '0;
      fu_b     <= '0;
      fu_aluop <= ALUOP_WIDTH'(ADD);
      op_tag   <= '0;
    end else if (issue) begin
      fu_a     <= head.a;
      fu_b     <= head.b;
      fu_aluop <= head.aluop;
      op_tag   <= head.tag;
    end
  end

  // Response register: loaded on capture or reject, otherwise held through any RESP stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rsp_data <= '0;
      rsp_tag  <= '0;
      rsp_err  <= 1'b0;
`ifdef SCALAR_FU_SEQ_SAT_EN
      rsp_sat  <= 1'b0;
`endif
    end else if (reject) begin
      rsp_data <= '0;
      rsp_tag  <= head.tag;
      rsp_err  <= 1'b1;
`ifdef SCALAR_FU_SEQ_SAT_EN
      rsp_sat  <= 1'b0;
`endif
    end else if (capture) begin
      rsp_data <= res_d;
      rsp_tag  <= op_tag;
      rsp_err  <= 1'b0;
`ifdef SCALAR_FU_SEQ_SAT_EN
      rsp_sat  <= res_clip;
`endif
    end
  end

endmodule

// File: tb/tb_scalar_fu_seq.sv
// Directed bench for scalar_fu_seq: one instance with FU_LAT=1, one with FU_LAT=3.
// Latency: n/a (bench). Each instance is fed by a behavioural combinational FU.
// Backpressure: exercised by holding rsp_ready low until the command FIFO fills.
module tb_scalar_fu_seq;

  logic CLK = 1'b0;
  logic nRST;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // FU_LAT=1 instance
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0]  cmd_aluop, fu_aluop;
  logic [7:0]  cmd_a, cmd_b, fu_a, fu_b;
  logic [3:0]  cmd_tag, rsp_tag;
  logic [15:0] fu_out, rsp_data;
  // FU_LAT=3 instance
  logic        s3_cmd_valid, s3_cmd_ready, s3_rsp_valid, s3_rsp_ready, s3_rsp_err, s3_busy;
  logic [2:0]  s3_cmd_aluop, s3_fu_aluop;
  logic [7:0]  s3_cmd_a, s3_cmd_b, s3_fu_a, s3_fu_b;
  logic [3:0]  s3_cmd_tag, s3_rsp_tag;
  logic [15:0] s3_fu_out, s3_rsp_data;
`ifdef SCALAR_FU_SEQ_SAT_EN
  logic        rsp_sat, s3_rsp_sat;
`endif

  function automatic logic [15:0] fu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    case (op)
      3'd0:    return sa + sb;
      3'd1:    return sa - sb;
      3'd2:    return sa * sb;
      3'd3:    return sa <<< b[2:0];
      3'd4:    return sa >>> b[2:0];
      default: return 16'h0000;
    endcase
  endfunction

  assign fu_out    = fu_model(fu_aluop, fu_a, fu_b);
  assign s3_fu_out = fu_model(s3_fu_aluop, s3_fu_a, s3_fu_b);

  scalar_fu_seq #(.FU_LAT(1)) dut (
    .CLK(CLK), .nRST(nRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_aluop(cmd_aluop),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .fu_a(fu_a), .fu_b(fu_b), .fu_aluop(fu_aluop), .fu_out(fu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
`ifdef SCALAR_FU_SEQ_SAT_EN
    , .rsp_sat(rsp_sat)
`endif
  );

  scalar_fu_seq #(.FU_LAT(3)) dut3 (
    .CLK(CLK), .nRST(nRST),
    .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready), .cmd_aluop(s3_cmd_aluop),
    .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b), .cmd_tag(s3_cmd_tag),
    .fu_a(s3_fu_a), .fu_b(s3_fu_b), .fu_aluop(s3_fu_aluop), .fu_out(s3_fu_out),
    .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_data(s3_rsp_data),
    .rsp_tag(s3_rsp_tag), .rsp_err(s3_rsp_err), .busy(s3_busy)
`ifdef SCALAR_FU_SEQ_SAT_EN
    , .rsp_sat(s3_rsp_sat)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    cmd_aluop = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit on3, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((on3 ? s3_rsp_valid : rsp_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    cmd_valid = 0; cmd_aluop = 0; cmd_a = 0; cmd_b = 0; cmd_tag = 0; rsp_ready = 0;
    s3_cmd_valid = 0; s3_cmd_aluop = 0; s3_cmd_a = 0; s3_cmd_b = 0; s3_cmd_tag = 0; s3_rsp_ready = 0;
    #2;
    checks++; if ({fu_a, fu_b, fu_aluop} !== 19'd0) begin failures++; $display("FAIL reset_fu got=%h exp=0", {fu_a, fu_b, fu_aluop}); end
    checks++; if ({rsp_valid, rsp_data, rsp_tag, rsp_err} !== 22'd0) begin failures++; $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_data, rsp_tag, rsp_err}); end
    checks++; if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL reset_rdy_busy got=%b exp=10", {cmd_ready, busy}); end
`ifdef SCALAR_FU_SEQ_SAT_EN
    checks++; if (rsp_sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", rsp_sat); end
`endif
    step(); step();
    nRST = 1'b1;
    step();
  endtask

  task automatic test_add_latency();
    rsp_ready = 1'b1;
    send(3'd0, 8'd5, 8'hFD, 4'd2);                // edge T
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL add_valid_T got=%b exp=0", rsp_valid); end
    step();                                        // edge T+1: popped, FU driven
    checks++; if (rsp_valid !== 1'b0 || fu_a !== 8'd5 || fu_b !== 8'hFD) begin failures++; $display("FAIL add_issue got=%b/%h/%h exp=0/05/fd", rsp_valid, fu_a, fu_b); end
    step();                                        // edge T+2: valid, seen by consumer at T+3
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL add_valid_T3 got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 16'd2 || rsp_tag !== 4'd2 || rsp_err !== 1'b0) begin failures++; $display("FAIL add_rsp got=%h/%h/%b exp=0002/2/0", rsp_data, rsp_tag, rsp_err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy_resp got=%b exp=1", busy); end
    step();                                        // edge T+3: handshake
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL add_done got=%b/%b exp=0/0", rsp_valid, busy); end
  endtask

  task automatic test_ops();
    bit ok;
    send(3'd2, 8'h80, 8'h80, 4'd3);
    wait_rsp(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mul_timeout got=no_rsp exp=rsp"); end
`ifdef SCALAR_FU_SEQ_SAT_EN
    checks++; if (rsp_data !== 16'h007F || rsp_sat !== 1'b1) begin failures++; $display("FAIL mul_sat got=%h/%b exp=007f/1", rsp_data, rsp_sat); end
`else
    checks++; if (rsp_data !== 16'h4000) begin failures++; $display("FAIL mul_data got=%h exp=4000", rsp_data); end
`endif
    checks++; if (rsp_tag !== 4'd3 || rsp_err !== 1'b0) begin failures++; $display("FAIL mul_tag got=%h/%b exp=3/0", rsp_tag, rsp_err); end
    step();
    send(3'd1, 8'd10, 8'd30, 4'd5);
    wait_rsp(1'b0, ok);
    checks++; if (!ok || rsp_data !== 16'hFFEC || rsp_tag !== 4'd5) begin failures++; $display("FAIL sna_rsp got=%b/%h/%h exp=1/ffec/5", ok, rsp_data, rsp_tag); end
`ifdef SCALAR_FU_SEQ_SAT_EN
    checks++; if (rsp_sat !== 1'b0) begin failures++; $display("FAIL sna_sat got=%b exp=0", rsp_sat); end
`endif
    step();
  endtask

  task automatic test_illegal();
    bit ok;
    send(3'd6, 8'h55, 8'h66, 4'd9);
    wait_rsp(1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ill_timeout got=no_rsp exp=rsp"); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 16'd0 || rsp_tag !== 4'd9) begin failures++; $display("FAIL ill_rsp got=%b/%h/%h exp=1/0000/9", rsp_err, rsp_data, rsp_tag); end
    checks++; if (fu_a !== 8'd10 || fu_b !== 8'd30 || fu_aluop !== 3'd1) begin failures++; $display("FAIL ill_fu_held got=%h/%h/%h exp=0a/1e/1", fu_a, fu_b, fu_aluop); end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc = 0;
    rsp_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cmd_aluop = 3'd0; cmd_a = 8'(i); cmd_b = 8'd0; cmd_tag = 4'(i); cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      step();
    end
    cmd_valid = 1'b0;
    checks++; if (acc !== 5) begin failures++; $display("FAIL bp_accepted got=%0d exp=5", acc); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_full_rdy got=%b exp=0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'd1 || rsp_data !== 16'd1) begin failures++; $display("FAIL bp_first got=%b/%h/%h exp=1/1/0001", rsp_valid, rsp_tag, rsp_data); end
    rsp_ready = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_rdy_before_pop got=%b exp=0", cmd_ready); end
    step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_rdy_after_pop got=%b exp=1", cmd_ready); end
    for (int k = 2; k <= 5; k++) begin
      wait_rsp(1'b0, ok);
      checks++; if (!ok || rsp_tag !== 4'(k) || rsp_data !== 16'(k)) begin failures++; $display("FAIL bp_order k=%0d got=%b/%h/%h exp=1/%h/%h", k, ok, rsp_tag, rsp_data, 4'(k), 16'(k)); end
      step();
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int n_rsp = 0, t1 = 0, t2 = 0, held = 0;
    s3_rsp_ready = 1'b1;
    s3_cmd_aluop = 3'd2; s3_cmd_a = 8'd7; s3_cmd_b = 8'hFA; s3_cmd_tag = 4'd1; s3_cmd_valid = 1'b1;
    step();
    s3_cmd_aluop = 3'd3; s3_cmd_a = 8'd3; s3_cmd_b = 8'd2; s3_cmd_tag = 4'd2;
    step();
    s3_cmd_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (s3_fu_a === 8'd7 && s3_fu_b === 8'hFA && s3_fu_aluop === 3'd2) held++;
      if (s3_rsp_valid === 1'b1) begin
        n_rsp++;
        if (n_rsp == 1) begin
          t1 = cyc;
          checks++; if (s3_rsp_data !== 16'hFFD6 || s3_rsp_tag !== 4'd1) begin failures++; $display("FAIL b2b_rsp1 got=%h/%h exp=ffd6/1", s3_rsp_data, s3_rsp_tag); end
        end else if (n_rsp == 2) begin
          t2 = cyc;
          checks++; if (s3_rsp_data !== 16'h000C || s3_rsp_tag !== 4'd2) begin failures++; $display("FAIL b2b_rsp2 got=%h/%h exp=000c/2", s3_rsp_data, s3_rsp_tag); end
        end
      end
      step();
    end
    checks++; if (n_rsp !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", n_rsp); end
    checks++; if (t2 - t1 !== 5) begin failures++; $display("FAIL b2b_spacing got=%0d exp=5", t2 - t1); end
    checks++; if (held !== 5) begin failures++; $display("FAIL b2b_fu_hold got=%0d exp=5", held); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    s3_rsp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s3_cmd_aluop = 3'd0; s3_cmd_a = 8'(i); s3_cmd_b = 8'd1; s3_cmd_tag = 4'(i); s3_cmd_valid = 1'b1;
      step();
    end
    s3_cmd_valid = 1'b0;
    checks++; if (s3_busy !== 1'b1 || s3_rsp_valid !== 1'b0 || s3_fu_a !== 8'd1) begin failures++; $display("FAIL mid_pre got=%b/%b/%h exp=1/0/01", s3_busy, s3_rsp_valid, s3_fu_a); end
    nRST = 1'b0;
    #1;
    checks++; if ({s3_fu_a, s3_fu_b, s3_fu_aluop} !== 19'd0) begin failures++; $display("FAIL mid_rst_fu got=%h exp=0", {s3_fu_a, s3_fu_b, s3_fu_aluop}); end
    checks++; if ({s3_rsp_valid, s3_rsp_data, s3_rsp_tag, s3_rsp_err} !== 22'd0) begin failures++; $display("FAIL mid_rst_rsp got=%h exp=0", {s3_rsp_valid, s3_rsp_data, s3_rsp_tag, s3_rsp_err}); end
    checks++; if ({s3_cmd_ready, s3_busy} !== 2'b10) begin failures++; $display("FAIL mid_rst_rdy got=%b exp=10", {s3_cmd_ready, s3_busy}); end
    step(); step();
    nRST = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s3_rsp_valid !== 1'b0 || s3_busy !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin failures++; $display("FAIL mid_stale got=%0d exp=0", stale); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_ops();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
